// File: rtl/led_fade_driver_pkg.sv
// Shared definitions for the LED fade output stage: FSM states, colour codes
// and the colour-to-RGB-enable mapping.
package led_fade_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_LOAD     = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_e;

  localparam logic [1:0] COL_WHITE = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  // Returns {en_r, en_g, en_b} for a colour code.
  function automatic logic [2:0] color_enables(input logic [1:0] color);
    case (color)
      COL_RED:   color_enables = 3'b100;
      COL_GREEN: color_enables = 3'b010;
      COL_BLUE:  color_enables = 3'b001;
      default:   color_enables = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/led_fade_driver_pwm_tick.sv
// Free-running 8-bit PWM counter plus the ramp prescaler that paces fades.
module led_pwm_tick #(
  parameter int unsigned RAMP_DIV = 390625
) (
  input  logic       clk0,
  input  logic       rst,
  output logic [7:0] pwm_cnt_o,
  output logic       tick_o
);

  localparam int unsigned RW = $clog2(RAMP_DIV);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  logic [7:0]    pwm_cnt_q;
  logic [RW-1:0] ramp_cnt_q;

  assign tick_o    = (ramp_cnt_q == RAMP_LAST);
  assign pwm_cnt_o = pwm_cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      pwm_cnt_q  <= '0;
      ramp_cnt_q <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_q + 8'd1;
      ramp_cnt_q <= tick_o ? '0 : ramp_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// LED output stage: accepts pattern/colour updates, fades the display out,
// swaps in the new pattern and colour, then fades back in under PWM control.
module led_fade_driver
  import led_fade_driver_pkg::*;
#(
  parameter int unsigned RAMP_DIV  = 390625,
  parameter int unsigned STEP      = 1,
  parameter int unsigned MAX_LEVEL = 255
) (
  input  logic       clk0,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pattern,
  input  logic [1:0] in_color,
  output logic [7:0] leds,
  output logic       rgb_r,
  output logic       rgb_g,
  output logic       rgb_b,
  output logic       busy
);

  localparam logic [7:0] STEP_L = 8'(STEP);
  localparam logic [7:0] MAX_L  = 8'(MAX_LEVEL);

  state_e     state_q, state_d;
  logic [7:0] level_q, level_d;
  logic [7:0] pend_pat_q, act_pat_q;
  logic [1:0] pend_col_q, act_col_q;
  logic [7:0] leds_q;
  logic [2:0] rgb_q;
  logic [7:0] pwm_cnt;
  logic       tick;
  logic       pwm_on;
  logic       xfer;

  led_pwm_tick #(.RAMP_DIV(RAMP_DIV)) u_pwm_tick (
    .clk0      (clk0),
    .rst       (rst),
    .pwm_cnt_o (pwm_cnt),
    .tick_o    (tick)
  );

  assign pwm_on = (pwm_cnt < level_q);
  assign xfer   = in_valid && in_ready;

  always_ff @(posedge clk0) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Level only moves on ramp ticks and saturates at 0 / MAX_LEVEL.
  always_comb begin
    // NOTE: defaults first so every path assigns; otherwise always_comb infers latches.
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_FADE_OUT;
      ST_FADE_OUT: begin
        if (level_q == 8'd0) state_d = ST_LOAD;
        else if (tick)       level_d = (level_q > STEP_L) ? level_q - STEP_L : 8'd0;
      end
      ST_LOAD: state_d = ST_FADE_IN;
      ST_FADE_IN: begin
        if (level_q == MAX_L) state_d = ST_IDLE;
        else if (tick)        level_d = (MAX_L - level_q > STEP_L) ? level_q + STEP_L : MAX_L;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk0) begin
    if (!rst) begin
      pend_pat_q <= '0;
      pend_col_q <= COL_WHITE;
      act_pat_q  <= '0;
      act_col_q  <= COL_WHITE;
      leds_q     <= '0;
      rgb_q      <= 3'b111;
    end else begin
      if (xfer) begin
        pend_pat_q <= in_pattern;
        pend_col_q <= in_color;
      end
      if (state_q == ST_LOAD) begin
        act_pat_q <= pend_pat_q;
        act_col_q <= pend_col_q;
      end
      leds_q <= act_pat_q & {8{pwm_on}};
      rgb_q  <= ~(color_enables(act_col_q) & {3{pwm_on}});
    end
  end

  assign leds  = leds_q;
  assign rgb_r = rgb_q[2];
  assign rgb_g = rgb_q[1];
  assign rgb_b = rgb_q[0];

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver: directed scenarios plus random
// updates, compared every cycle against a cycle-count based reference model.
module tb_led_fade_driver;

  localparam int RAMP_DIV  = 4;
  localparam int STEP      = 64;
  localparam int MAX_LEVEL = 255;

  localparam int M_IDLE = 0, M_OUT = 1, M_LOAD = 2, M_IN = 3;

  logic       clk0 = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pattern = 8'h00;
  logic [1:0] in_color = 2'd0;
  logic       in_ready, rgb_r, rgb_g, rgb_b, busy;
  logic [7:0] leds;

  always #5 clk0 = ~clk0;

  led_fade_driver #(.RAMP_DIV(RAMP_DIV), .STEP(STEP), .MAX_LEVEL(MAX_LEVEL)) dut (
    .clk0       (clk0),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pattern (in_pattern),
    .in_color   (in_color),
    .leds       (leds),
    .rgb_r      (rgb_r),
    .rgb_g      (rgb_g),
    .rgb_b      (rgb_b),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timing derived from cycles elapsed since reset.
  int         m_mode, m_level, m_cyc;
  logic [7:0] m_pend_pat, m_act_pat, m_leds;
  logic [1:0] m_pend_col, m_act_col;
  logic [2:0] m_rgb;
  bit         m_xfer;

  function automatic logic [2:0] col_mask(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_edge();
    bit on, tick;
    m_xfer = 1'b0;
    if (!rst) begin
      m_mode = M_IDLE; m_level = 0; m_cyc = 0;
      m_pend_pat = 8'h00; m_pend_col = 2'd0;
      m_act_pat = 8'h00; m_act_col = 2'd0;
      m_leds = 8'h00; m_rgb = 3'b111;
      return;
    end
    on   = (m_cyc % 256) < m_level;
    tick = (m_cyc % RAMP_DIV) == RAMP_DIV - 1;
    m_leds = on ? m_act_pat : 8'h00;
    m_rgb  = on ? ~col_mask(m_act_col) : 3'b111;
    case (m_mode)
      M_IDLE: if (in_valid) begin
        m_xfer = 1'b1; m_pend_pat = in_pattern; m_pend_col = in_color; m_mode = M_OUT;
      end
      M_OUT: begin
        if (m_level == 0) m_mode = M_LOAD;
        else if (tick)    m_level = (m_level > STEP) ? m_level - STEP : 0;
      end
      M_LOAD: begin
        m_act_pat = m_pend_pat; m_act_col = m_pend_col; m_mode = M_IN;
      end
      default: begin
        if (m_level == MAX_LEVEL) m_mode = M_IDLE;
        else if (tick)            m_level = (MAX_LEVEL - m_level > STEP) ? m_level + STEP : MAX_LEVEL;
      end
    endcase
    m_cyc++;
  endtask

  task automatic cycle();
    @(posedge clk0);
    model_edge();
    #1;
    check("leds", 32'(leds), 32'(m_leds));
    check("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(m_rgb));
    check("in_ready", 32'(in_ready), 32'(m_mode == M_IDLE));
    check("busy", 32'(busy), 32'(m_mode != M_IDLE));
    check("level", 32'(dut.level_q), 32'(m_level));
  endtask

  task automatic send(input logic [7:0] pat, input logic [1:0] col);
    in_pattern = pat;
    in_color   = col;
    in_valid   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (m_xfer) break;
    end
    check("xfer_timeout", 32'(m_xfer), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (in_ready === 1'b1 && m_mode == M_IDLE) break;
      cycle();
    end
    check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int c_l0, c_l1, c_r, c_g, c_b, c_leds, waited;

    // 1: reset for 3 cycles, then quiet idle
    rst = 1'b0;
    repeat (3) cycle();
    check("rst_leds", 32'(leds), 32'h00);
    check("rst_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h7);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (512) cycle();

    // 2: first update from reset, then duty measurement
    send(8'hA5, 2'd1);
    wait_idle();
    c_l0 = 0; c_l1 = 0; c_r = 0; c_g = 0; c_b = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      c_l0 += int'(leds[0]); c_l1 += int'(leds[1]);
      c_r += int'(!rgb_r); c_g += int'(!rgb_g); c_b += int'(!rgb_b);
    end
    check("duty_led0", 32'(c_l0), 32'd255);
    check("duty_led1", 32'(c_l1), 32'd0);
    check("duty_r", 32'(c_r), 32'd255);
    check("duty_g", 32'(c_g), 32'd0);
    check("duty_b", 32'(c_b), 32'd0);

    // 3: full fade-out / fade-in swap
    send(8'h0F, 2'd2);
    wait_idle();
    check("s3_level", 32'(dut.level_q), 32'd255);

    // 4: request held during FADE_IN is deferred to IDLE
    send(8'h81, 2'd0);
    for (int i = 0; i < 200 && m_mode != M_IN; i++) cycle();
    in_pattern = 8'h3C; in_color = 2'd3; in_valid = 1'b1;
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (m_xfer) break;
      if (in_ready === 1'b0) waited++;
    end
    in_valid = 1'b0;
    check("s4_xfer", 32'(m_xfer), 32'd1);
    check("s4_held", 32'(waited > 0), 32'd1);
    wait_idle();

    // 5: reset mid-FADE_IN at level 128
    send(8'h55, 2'd1);
    for (int i = 0; i < 200 && !(m_mode == M_IN && m_level == 128); i++) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("s5_leds", 32'(leds), 32'h00);
    check("s5_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h7);
    check("s5_level", 32'(dut.level_q), 32'd0);
    check("s5_ready", 32'(in_ready), 32'd1);
    repeat (300) cycle();

    // 6: blank pattern, white colour at full level
    send(8'h00, 2'd0);
    wait_idle();
    c_r = 0; c_g = 0; c_b = 0; c_leds = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      c_r += int'(!rgb_r); c_g += int'(!rgb_g); c_b += int'(!rgb_b);
      c_leds += int'(leds != 8'h00);
    end
    check("s6_r", 32'(c_r), 32'd255);
    check("s6_g", 32'(c_g), 32'd255);
    check("s6_b", 32'(c_b), 32'd255);
    check("s6_leds", 32'(c_leds), 32'd0);

    // Random updates, gaps, early requests and occasional resets
    for (int n = 0; n < 150; n++) begin
      send(8'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 40)) cycle();
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        cycle();
        rst = 1'b1;
      end
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
